// File: rtl/shared_bus_receiver.sv
// Receiver for the shared tri-state data bus: samples one-hot granted words into a
// small FIFO tagged with the source index and flags grant conflicts.
module shared_bus_receiver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SRC_BITS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    input  logic [NUM_SRC-1:0]       bus_grant,
    input  logic                     bus_valid,
    output logic                     bus_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [SRC_BITS-1:0]      out_src,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     conflict,
    input  logic                     conflict_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [SRC_BITS-1:0]   src_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             conflict_q, conflict_d;

    logic               full, empty, onehot, multi, push, pop;
    logic [NUM_SRC-1:0] grant_minus_one;
    logic [SRC_BITS-1:0] src_enc;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);

        // x & (x-1) clears the lowest set bit; anything left means two or more grants
        grant_minus_one = bus_grant - NUM_SRC'(1);
        multi  = |(bus_grant & grant_minus_one);
        onehot = (|bus_grant) && !multi;

        src_enc = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus_grant[i]) src_enc = SRC_BITS'(i);
        end

        bus_ready = !full && !flush;
        out_valid = !empty;
        push      = bus_valid && bus_ready && onehot;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        conflict_d = conflict_q;
        if (conflict_clr)         conflict_d = 1'b0;
        if (bus_valid && multi)   conflict_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            conflict_q <= conflict_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus_data;
            src_mem[wr_ptr_q]  <= src_enc;
        end
    end

    assign out_data = data_mem[rd_ptr_q];
    assign out_src  = src_mem[rd_ptr_q];
    assign count    = count_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_shared_bus_receiver.sv
// Directed bench for shared_bus_receiver: inputs change and outputs are checked on
// the falling edge, away from the active rising edge.
module tb_shared_bus_receiver;

    logic        clk;
    logic        reset_n;
    logic [31:0] bus_data;
    logic [3:0]  bus_grant;
    logic        bus_valid;
    logic        bus_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;
    logic        conflict;
    logic        conflict_clr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    shared_bus_receiver #(
        .DATA_WIDTH (32),
        .NUM_SRC    (4),
        .SRC_BITS   (2),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus_data     (bus_data),
        .bus_grant    (bus_grant),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .flush        (flush),
        .count        (count),
        .conflict     (conflict),
        .conflict_clr (conflict_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        bus_data     = '0;
        bus_grant    = '0;
        bus_valid    = 1'b0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        conflict_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_bus_ready", bus_ready, 1);
        check_eq("rst_count",     count,     0);
        check_eq("rst_conflict",  conflict,  0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single push from source 2
        bus_grant = 4'b0100; bus_data = 32'hDEAD_BEEF; bus_valid = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out_data",  out_data,  32'hDEAD_BEEF);
        check_eq("t1_out_src",   out_src,   2);
        check_eq("t1_count",     count,     1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t1_drained", count, 0);

        // Fill to full; fifth word must be refused
        bus_grant = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            bus_data = 32'(i); bus_valid = 1'b1;
            @(negedge clk);
        end
        bus_data = 32'd5;
        check_eq("t2_count_full", count,     4);
        check_eq("t2_ready_full", bus_ready, 0);
        @(negedge clk);
        check_eq("t2_count_held", count,    4);
        check_eq("t2_head",       out_data, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; bus_valid = 1'b0;
        check_eq("t2_count_pop",  count,     3);
        check_eq("t2_ready_back", bus_ready, 1);
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            check_eq("t2_drain_data", out_data, 32'(k));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("t2_empty", count, 0);

        // Streaming: push and pop each cycle, pointers wrap
        out_ready = 1'b1; bus_grant = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            bus_data = 32'h10 + 32'(i); bus_valid = 1'b1;
            @(negedge clk);
            check_eq("t3_valid", out_valid, 1);
            check_eq("t3_data",  out_data,  32'h10 + 32'(i));
            check_eq("t3_count", count,     1);
        end
        bus_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t3_empty", count, 0);

        // Grant conflict
        bus_grant = 4'b0011; bus_data = 32'h1234; bus_valid = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        check_eq("t4_conflict_set", conflict, 1);
        check_eq("t4_no_push",      count,    0);
        repeat (5) @(negedge clk);
        check_eq("t4_conflict_hold", conflict, 1);
        conflict_clr = 1'b1;
        @(negedge clk);
        conflict_clr = 1'b0;
        check_eq("t4_conflict_clr", conflict, 0);
        conflict_clr = 1'b1; bus_valid = 1'b1;
        @(negedge clk);
        conflict_clr = 1'b0; bus_valid = 1'b0;
        check_eq("t4_set_wins", conflict, 1);
        conflict_clr = 1'b1;
        @(negedge clk);
        conflict_clr = 1'b0;
        bus_grant = 4'b0000; bus_valid = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        check_eq("t4_zero_grant_count",    count,    0);
        check_eq("t4_zero_grant_conflict", conflict, 0);

        // Flush with simultaneous push and pop at count 3
        bus_grant = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            bus_data = 32'hA0 + 32'(i); bus_valid = 1'b1;
            @(negedge clk);
        end
        check_eq("t5_count3", count, 3);
        flush = 1'b1; bus_data = 32'hAA; out_ready = 1'b1;
        #1;
        check_eq("t5_ready_flush", bus_ready, 0);
        @(negedge clk);
        flush = 1'b0; bus_valid = 1'b0; out_ready = 1'b0;
        check_eq("t5_count", count,     0);
        check_eq("t5_valid", out_valid, 0);

        // Asynchronous reset mid-cycle
        bus_grant = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            bus_data = 32'hB0 + 32'(i); bus_valid = 1'b1;
            @(negedge clk);
        end
        bus_grant = 4'b1100;
        @(negedge clk);
        bus_valid = 1'b0;
        check_eq("t6_pre_count",    count,    2);
        check_eq("t6_pre_conflict", conflict, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_valid",    out_valid, 0);
        check_eq("t6_rst_count",    count,     0);
        check_eq("t6_rst_conflict", conflict,  0);
        check_eq("t6_rst_ready",    bus_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        bus_grant = 4'b1000; bus_data = 32'hCAFE; bus_valid = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        check_eq("t6_src",   out_src,  3);
        check_eq("t6_data",  out_data, 32'hCAFE);
        check_eq("t6_count", count,    1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
